// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared pipeline control types and constants
package core_ctrl_pkg;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int MULDIV_LAT_DEFAULT = 4;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use hazard comparator between ID sources and EX load
module load_use_detect
   import core_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   output logic       load_use
);

   // x0 is never a real dependency since it always reads as zero
   always_comb begin
      load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));
   end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// rtl/pipeline_hazard_sequencer.sv - stall/flush controller with mul/div issue and stall counter
module pipeline_hazard_sequencer
   import core_ctrl_pkg::*;
#(
   parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
   parameter int CNT_W      = 16
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_uses_rs1,
   input  logic             ID_uses_rs2,
   input  logic             ID_is_muldiv,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_rd,
   input  logic             EX_branch_taken,
   output logic             PC_write,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_bubble,
   output logic             muldiv_start,
   output logic             muldiv_abort,
   output logic             muldiv_done,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int MD_W = $clog2(MULDIV_LAT + 1);

   state_t            state_q, state_d;
   logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
   logic              load_use;

   load_use_detect u_load_use_detect (
      .id_rs1      (ID_rs1),
      .id_rs2      (ID_rs2),
      .id_uses_rs1 (ID_uses_rs1),
      .id_uses_rs2 (ID_uses_rs2),
      .ex_mem_read (EX_MemRead),
      .ex_rd       (EX_rd),
      .load_use    (load_use)
   );

   always_comb begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
      muldiv_start = 1'b0;
      muldiv_abort = 1'b0;
      muldiv_done  = 1'b0;
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;

      if (reset) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         IF_ID_flush  = 1'b1;
         ID_EX_bubble = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (EX_branch_taken) begin
                  IF_ID_flush  = 1'b1;
                  ID_EX_bubble = 1'b1;
               end else if (load_use) begin
                  PC_write     = 1'b0;
                  IF_ID_write  = 1'b0;
                  ID_EX_bubble = 1'b1;
               end else if (ID_is_muldiv) begin
                  muldiv_start = 1'b1;
                  if (MULDIV_LAT == 1) begin
                     muldiv_done = 1'b1;
                  end else begin
                     PC_write     = 1'b0;
                     IF_ID_write  = 1'b0;
                     ID_EX_bubble = 1'b1;
                     md_cnt_d     = MD_W'(MULDIV_LAT - 1);
                     state_d      = MD_WAIT;
                  end
               end
            end
            MD_WAIT: begin
               // An older redirect kills the mul/div that is still sitting in ID
               if (EX_branch_taken) begin
                  muldiv_abort = 1'b1;
                  IF_ID_flush  = 1'b1;
                  ID_EX_bubble = 1'b1;
                  md_cnt_d     = '0;
                  state_d      = RUN;
               end else if (md_cnt_q > MD_W'(1)) begin
                  PC_write     = 1'b0;
                  IF_ID_write  = 1'b0;
                  ID_EX_bubble = 1'b1;
                  md_cnt_d     = md_cnt_q - MD_W'(1);
               end else begin
                  muldiv_done = 1'b1;
                  md_cnt_d    = '0;
                  state_d     = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end

      stall_cycles_d = stall_cycles_q;
      if (!PC_write && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         md_cnt_q       <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         md_cnt_q       <= md_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb/tb_pipeline_hazard_sequencer.sv - directed and random checks against a cycle-level reference model
module tb_pipeline_hazard_sequencer;

   localparam int LAT = 4;
   localparam int CW  = 16;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    ID_rs1, ID_rs2, EX_rd;
   logic          ID_uses_rs1, ID_uses_rs2, ID_is_muldiv, EX_MemRead, EX_branch_taken;
   logic          PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
   logic          muldiv_start, muldiv_abort, muldiv_done;
   logic [CW-1:0] stall_cycles;

   int total = 0;
   int bad   = 0;

   // Reference model: how many cycles the outstanding mul/div has already spent in ID
   int md_elapsed = 0;
   int m_stalls   = 0;
   bit e_pc, e_ifid, e_flush, e_bubble, e_start, e_abort, e_done;

   pipeline_hazard_sequencer #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
      .ID_is_muldiv(ID_is_muldiv), .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
      .EX_branch_taken(EX_branch_taken),
      .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
      .ID_EX_bubble(ID_EX_bubble), .muldiv_start(muldiv_start),
      .muldiv_abort(muldiv_abort), .muldiv_done(muldiv_done),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_stall_pattern(input bit pc, input bit flush, input bit bub);
      e_pc = pc; e_ifid = pc; e_flush = flush; e_bubble = bub;
   endtask

   task automatic model_comb();
      bit lu;
      lu = EX_MemRead && (EX_rd != 0) &&
           ((ID_uses_rs1 && ID_rs1 == EX_rd) || (ID_uses_rs2 && ID_rs2 == EX_rd));
      e_start = 0; e_abort = 0; e_done = 0;
      set_stall_pattern(1, 0, 0);
      if (reset) begin
         set_stall_pattern(0, 1, 1);
      end else if (md_elapsed > 0) begin
         if (EX_branch_taken) begin
            e_abort = 1;
            set_stall_pattern(1, 1, 1);
         end else if (md_elapsed == LAT - 1) begin
            e_done = 1;
         end else begin
            set_stall_pattern(0, 0, 1);
         end
      end else if (EX_branch_taken) begin
         set_stall_pattern(1, 1, 1);
      end else if (lu) begin
         set_stall_pattern(0, 0, 1);
      end else if (ID_is_muldiv) begin
         e_start = 1;
         if (LAT == 1) e_done = 1;
         else set_stall_pattern(0, 0, 1);
      end
   endtask

   task automatic model_seq();
      if (reset) begin
         md_elapsed = 0;
         m_stalls   = 0;
      end else begin
         if (!e_pc && m_stalls < CNT_MAX) m_stalls++;
         if (md_elapsed > 0) begin
            if (e_abort || e_done) md_elapsed = 0;
            else md_elapsed++;
         end else if (e_start && !e_done) begin
            md_elapsed = 1;
         end
      end
   endtask

   task automatic step(input bit chk_en);
      #1;
      model_comb();
      if (chk_en) begin
         chk("PC_write",     PC_write,     e_pc);
         chk("IF_ID_write",  IF_ID_write,  e_ifid);
         chk("IF_ID_flush",  IF_ID_flush,  e_flush);
         chk("ID_EX_bubble", ID_EX_bubble, e_bubble);
         chk("muldiv_start", muldiv_start, e_start);
         chk("muldiv_abort", muldiv_abort, e_abort);
         chk("muldiv_done",  muldiv_done,  e_done);
         chk("stall_cycles", stall_cycles, m_stalls);
      end
      @(posedge clk);
      model_seq();
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 0; ID_rs1 = 0; ID_rs2 = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
      ID_is_muldiv = 0; EX_MemRead = 0; EX_rd = 0; EX_branch_taken = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      @(negedge clk);

      // reset held two cycles, then released with no hazards
      step(1);
      step(1);
      reset = 0;
      #1;
      chk("run_pc_after_reset", PC_write, 1'b1);
      chk("stall_after_reset", stall_cycles, 16'd0);
      step(1);

      // load-use on rs1, then the same pattern against x0
      EX_MemRead = 1; EX_rd = 5; ID_rs1 = 5; ID_uses_rs1 = 1;
      step(1);
      chk("lu_stall_count", stall_cycles, 16'd1);
      EX_rd = 0; ID_rs1 = 0;
      step(1);
      chk("x0_no_stall", stall_cycles, 16'd1);
      idle();
      step(1);

      // full-latency mul/div
      ID_is_muldiv = 1;
      for (int i = 0; i < LAT; i++) step(1);
      ID_is_muldiv = 0;
      chk("muldiv_stall_count", stall_cycles, 16'd4);
      step(1);

      // branch beats load-use and mul/div in the same cycle
      EX_branch_taken = 1; ID_is_muldiv = 1;
      EX_MemRead = 1; EX_rd = 7; ID_rs2 = 7; ID_uses_rs2 = 1;
      step(1);
      idle();
      step(1);

      // abort on first wait cycle
      ID_is_muldiv = 1;
      step(1);
      ID_is_muldiv = 0; EX_branch_taken = 1;
      step(1);
      idle();
      step(1);

      // reset while waiting, then a clean full-latency issue
      ID_is_muldiv = 1;
      step(1);
      ID_is_muldiv = 0;
      step(1);
      reset = 1;
      step(1);
      reset = 0;
      step(1);
      ID_is_muldiv = 1;
      for (int i = 0; i < LAT; i++) step(1);
      idle();
      step(1);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         reset           = ($urandom_range(0, 99) < 3);
         ID_rs1          = 5'($urandom_range(0, 3));
         ID_rs2          = 5'($urandom_range(0, 3));
         EX_rd           = 5'($urandom_range(0, 3));
         ID_uses_rs1     = 1'($urandom);
         ID_uses_rs2     = 1'($urandom);
         EX_MemRead      = 1'($urandom);
         ID_is_muldiv    = ($urandom_range(0, 99) < 30);
         EX_branch_taken = ($urandom_range(0, 99) < 12);
         step(1);
      end

      // saturate the stall counter with a continuous load-use
      idle();
      reset = 1;
      step(1);
      reset = 0;
      EX_MemRead = 1; EX_rd = 9; ID_rs1 = 9; ID_uses_rs1 = 1;
      for (int n = 0; n < 70000; n++) step(0);
      chk("stall_saturated", stall_cycles, 16'hFFFF);
      for (int n = 0; n < 4; n++) step(1);
      chk("stall_holds", stall_cycles, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
